// File: rtl/scope_pkg.sv
// ============================================================================
// Module      : scope_pkg
// Description : Shared types and defaults for the scope capture buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scope_pkg;

    localparam int c_data_w_default = 8;
    localparam int c_depth_default  = 256;

    typedef logic [c_data_w_default-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/scope_frame_ram.sv
// ============================================================================
// Module      : scope_frame_ram
// Description : Simple dual-port frame RAM, one write port and one registered
//               read port, coded for block RAM inference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scope_frame_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_words = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_words];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array itself keeps stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/scope_capture_buf.sv
// ============================================================================
// Module      : scope_capture_buf
// Description : Rising-edge triggered single-frame capture buffer with a
//               random-access readout port and ready/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scope_capture_buf
    import scope_pkg::*;
#(
    parameter int DATA_W = c_data_w_default,
    parameter int DEPTH  = c_depth_default,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              arm,
    input  logic              auto_rearm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] r_prev_sample;
    logic              r_prev_ok;
    logic              r_frame_ready;
    logic              r_busy;
    logic              w_trig;
    logic              w_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_prev_sample <= '0;
            r_prev_ok     <= 1'b0;
            r_frame_ready <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_frame_ready <= (w_state_nxt == DONE);
            r_busy        <= (w_state_nxt == ARMED) || (w_state_nxt == CAPTURE);
            // Each entry into ARMED must see a fresh sample before it can fire.
            if ((r_state == ARMED) && sample_valid) begin
                r_prev_sample <= sample_in;
                r_prev_ok     <= 1'b1;
            end else if ((w_state_nxt == ARMED) && (r_state != ARMED)) begin
                r_prev_ok     <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_waddr      = r_wr_ptr;
        w_we         = 1'b0;
        w_trig       = sample_valid && r_prev_ok &&
                       (r_prev_sample < trig_level) && (sample_in >= trig_level);
        case (r_state)
            IDLE: begin
                if (arm) begin
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (w_trig) begin
                    w_we         = 1'b1;
                    w_waddr      = '0;
                    w_wr_ptr_nxt = ADDR_W'(1);
                    w_state_nxt  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
                    if (r_wr_ptr == c_last_addr) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (frame_ack) begin
                    w_state_nxt = auto_rearm ? ARMED : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    scope_frame_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_frame_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (sample_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign frame_ready = r_frame_ready;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_scope_capture_buf.sv
// ============================================================================
// Module      : tb_scope_capture_buf
// Description : Directed self-checking bench for scope_capture_buf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scope_capture_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic [7:0] trig_level;
    logic       arm;
    logic       auto_rearm;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic       frame_ack;
    logic       busy;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    scope_capture_buf #(
        .DATA_W (8),
        .DEPTH  (256),
        .ADDR_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .arm          (arm),
        .auto_rearm   (auto_rearm),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_ready  (frame_ready),
        .frame_ack    (frame_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] e, input string tag);
        logic [7:0] x;
        rd_addr = a;
        exp_q.push_back(e);
        step();
        x = exp_q.pop_front();
        chk(tag, 32'(rd_data), 32'(x));
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    // Continuous ramp 0,1,2,... ; trigger lands on sample lvl, frame holds lvl+a.
    task automatic ramp(input logic [7:0] lvl, input int n, input string tag);
        trig_level = lvl;
        for (int i = 0; i < n; i++) begin
            sample_in    = 8'(i);
            sample_valid = 1'b1;
            step();
            chk(tag, 32'(frame_ready), 32'(i >= int'(lvl) + 255));
        end
        sample_valid = 1'b0;
    endtask

    task automatic frame_chk(input logic [7:0] lvl, input string tag);
        for (int a = 0; a < 256; a++) begin
            rd_chk(8'(a), 8'(int'(lvl) + a), tag);
        end
    endtask

    initial begin
        reset        = 1'b0;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        trig_level   = 8'h00;
        arm          = 1'b0;
        auto_rearm   = 1'b0;
        rd_addr      = 8'h00;
        frame_ack    = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(frame_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        reset = 1'b1;
        step();

        // Test 1: ramp capture at level 0x80
        pulse_arm();
        chk("t1_busy_armed", 32'(busy), 32'(1));
        ramp(8'h80, 400, "t1_ready");
        chk("t1_busy_done", 32'(busy), 32'(0));
        rd_chk(8'd0, 8'h80, "t1_ram0");
        rd_chk(8'd127, 8'hFF, "t1_ram127");
        rd_chk(8'd128, 8'h00, "t1_ram128");
        frame_chk(8'h80, "t1_frame");

        // Test 2: constant level above threshold never triggers
        pulse_ack();
        chk("t2_ack_ready", 32'(frame_ready), 32'(0));
        chk("t2_ack_busy", 32'(busy), 32'(0));
        trig_level   = 8'h80;
        sample_in    = 8'h90;
        sample_valid = 1'b1;
        pulse_arm();
        for (int i = 0; i < 1000; i++) begin
            step();
            chk("t2_hold", 32'({busy, frame_ready}), 32'(2'b10));
        end
        sample_valid = 1'b0;
        rd_chk(8'd0, 8'h80, "t2_no_write");

        // Test 3: sparse valid, crossing 0x10 -> 0xA0 at level 0x50
        trig_level = 8'h50;
        sample_in  = 8'hEE;
        step();
        step();
        sample_in = 8'h10; sample_valid = 1'b1; step();
        sample_in = 8'hEE; sample_valid = 1'b0; step(); step();
        sample_in = 8'hA0; sample_valid = 1'b1; step();
        chk("t3_trig_busy", 32'({busy, frame_ready}), 32'(2'b10));
        for (int k = 1; k <= 260; k++) begin
            sample_in = 8'hEE; sample_valid = 1'b0; step(); step();
            sample_in = 8'(k) ^ 8'h5A; sample_valid = 1'b1; step();
            chk("t3_ready", 32'(frame_ready), 32'(k >= 255));
        end
        sample_valid = 1'b0;
        rd_chk(8'd0, 8'hA0, "t3_ram0");
        for (int a = 1; a < 256; a++) begin
            rd_chk(8'(a), 8'(a) ^ 8'h5A, "t3_frame");
        end

        // Test 4: ack handling with and without auto_rearm
        auto_rearm = 1'b0;
        pulse_arm();
        chk("t4_arm_ign_ready", 32'(frame_ready), 32'(1));
        chk("t4_arm_ign_busy", 32'(busy), 32'(0));
        rd_chk(8'd0, 8'hA0, "t4_frozen");
        pulse_ack();
        chk("t4_idle_ready", 32'(frame_ready), 32'(0));
        chk("t4_idle_busy", 32'(busy), 32'(0));
        step();
        chk("t4_idle_stay", 32'(busy), 32'(0));
        pulse_arm();
        chk("t4_rearm_busy", 32'(busy), 32'(1));
        ramp(8'h40, 8'h40 + 258, "t4_ready_a");
        rd_chk(8'd0, 8'h40, "t4_ram0_a");
        auto_rearm = 1'b1;
        pulse_ack();
        chk("t4_auto_ready", 32'(frame_ready), 32'(0));
        chk("t4_auto_busy", 32'(busy), 32'(1));
        // Test 6b: ack in ARMED ignored
        pulse_ack();
        chk("t6_ack_armed", 32'({busy, frame_ready}), 32'(2'b10));
        ramp(8'h20, 8'h20 + 258, "t4_ready_b");
        rd_chk(8'd0, 8'h20, "t4_ram0_b");
        rd_chk(8'd255, 8'h1F, "t4_ram255_b");

        // Test 5: reset mid-capture at wr_ptr 100
        pulse_ack();
        chk("t5_armed", 32'(busy), 32'(1));
        ramp(8'h10, 8'h10 + 100, "t5_ready");
        #2;
        reset = 1'b0;
        #1;
        chk("t5_abort_ready", 32'(frame_ready), 32'(0));
        chk("t5_abort_busy", 32'(busy), 32'(0));
        chk("t5_abort_rd", 32'(rd_data), 32'(0));
        step();
        reset = 1'b1;
        step();
        chk("t5_idle_busy", 32'(busy), 32'(0));
        rd_chk(8'd0, 8'h10, "t5_stale0");
        rd_chk(8'd99, 8'h73, "t5_stale99");
        rd_chk(8'd100, 8'h84, "t5_stale100");
        rd_chk(8'd150, 8'hB6, "t5_stale150");
        auto_rearm = 1'b0;
        pulse_arm();
        ramp(8'h60, 8'h60 + 258, "t5_ready_new");
        rd_chk(8'd0, 8'h60, "t5_new0");
        rd_chk(8'd99, 8'hC3, "t5_new99");
        rd_chk(8'd255, 8'h5F, "t5_new255");

        // Test 6: arm + ack together in DONE, ack wins
        arm       = 1'b1;
        frame_ack = 1'b1;
        step();
        arm       = 1'b0;
        frame_ack = 1'b0;
        chk("t6_both_ready", 32'(frame_ready), 32'(0));
        chk("t6_both_busy", 32'(busy), 32'(0));
        step();
        chk("t6_stay_idle", 32'(busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
